rr_input_arbiter: RTL and testbench

//  Round-robin arbiter that merges NUM_QUEUES per-port input streams (MAC/CPU rx queues) into one

---
 rtl/rr_input_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_rr_input_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_input_arbiter.sv
// Round-robin merge of NUM_QUEUES packet streams into one output stream.
// Each input has a small FIFO; whole packets are granted atomically.
module rr_input_arbiter #(
  parameter int DATA_WIDTH        = 64,
  parameter int CTRL_WIDTH        = DATA_WIDTH/8,
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int NUM_QUEUES        = 4,
  parameter int FIFO_DEPTH_BITS   = 2,
  parameter int REG_ADDR_WIDTH    = 23,
  parameter int REG_DATA_WIDTH    = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
  input  logic [NUM_QUEUES-1:0]            in_wr,
  output logic [NUM_QUEUES-1:0]            in_rdy,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  input  logic                             reg_req_in,
  input  logic                             reg_ack_in,
  input  logic                             reg_rd_wr_L_in,
  input  logic [REG_ADDR_WIDTH-1:0]        reg_addr_in,
  input  logic [REG_DATA_WIDTH-1:0]        reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]     reg_src_in,
  output logic                             reg_req_out,
  output logic                             reg_ack_out,
  output logic                             reg_rd_wr_L_out,
  output logic [REG_ADDR_WIDTH-1:0]        reg_addr_out,
  output logic [REG_DATA_WIDTH-1:0]        reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]     reg_src_out
);

  localparam int PW    = FIFO_DEPTH_BITS;
  localparam int DEPTH = 2**PW;
  localparam int QW    = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
  localparam int RW    = 3 + REG_ADDR_WIDTH + REG_DATA_WIDTH + UDP_REG_SRC_WIDTH;
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_NF   = (PW+1)'(DEPTH-1);
  localparam logic [QW-1:0] LAST_RST = QW'(NUM_QUEUES-1);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

  logic [DATA_WIDTH-1:0] mem_data_q [NUM_QUEUES][DEPTH];
  logic [CTRL_WIDTH-1:0] mem_ctrl_q [NUM_QUEUES][DEPTH];
  logic [PW-1:0]         wr_ptr_q [NUM_QUEUES];
  logic [PW-1:0]         wr_ptr_d [NUM_QUEUES];
  logic [PW-1:0]         rd_ptr_q [NUM_QUEUES];
  logic [PW-1:0]         rd_ptr_d [NUM_QUEUES];
  logic [PW:0]           cnt_q    [NUM_QUEUES];
  logic [PW:0]           cnt_d    [NUM_QUEUES];

  logic [NUM_QUEUES-1:0] empty, full, nearly_full, rd_en, wr_en;
  logic                  rd_any;
  logic [DATA_WIDTH-1:0] head_data_g;
  logic [CTRL_WIDTH-1:0] head_ctrl_g;
  logic [QW:0]           pick;

  state_t                state_q, state_d;
  logic [QW-1:0]         grant_q, grant_d;
  logic [QW-1:0]         last_grant_q, last_grant_d;
  logic                  out_wr_q, out_wr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
  logic [RW-1:0]         ring_q, ring_d;

  // First non-empty input after 'last' in round-robin order; MSB flags a hit.
  function automatic logic [QW:0] rr_next(input logic [NUM_QUEUES-1:0] nonempty,
                                          input logic [QW-1:0] last);
    logic [QW:0] r;
    int          idx;
    r = '0;
    for (int k = NUM_QUEUES; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_QUEUES;
      if (nonempty[QW'(idx)]) r = {1'b1, QW'(idx)};
    end
    return r;
  endfunction

  always_comb begin
    empty       = '0;
    full        = '0;
    nearly_full = '0;
    rd_en       = '0;
    wr_en       = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      empty[i]       = (cnt_q[i] == '0);
      full[i]        = (cnt_q[i] == CNT_FULL);
      nearly_full[i] = (cnt_q[i] >= CNT_NF);
      rd_en[i]       = (grant_q == QW'(i)) && out_rdy && !empty[i] && (state_q != IDLE);
      // A full FIFO still accepts a word in the cycle it is being read.
      wr_en[i]       = in_wr[i] && (!full[i] || rd_en[i]);
      wr_ptr_d[i]    = wr_ptr_q[i] + {{(PW-1){1'b0}}, wr_en[i]};
      rd_ptr_d[i]    = rd_ptr_q[i] + {{(PW-1){1'b0}}, rd_en[i]};
      cnt_d[i]       = cnt_q[i] + {{PW{1'b0}}, wr_en[i]} - {{PW{1'b0}}, rd_en[i]};
    end
    rd_any      = |rd_en;
    head_data_g = mem_data_q[grant_q][rd_ptr_q[grant_q]];
    head_ctrl_g = mem_ctrl_q[grant_q][rd_ptr_q[grant_q]];
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pick         = rr_next(~empty, last_grant_q);
    case (state_q)
      IDLE: begin
        if (pick[QW]) begin
          grant_d = pick[QW-1:0];
          state_d = HDR;
        end
      end
      HDR: begin
        if (rd_any && head_ctrl_g == '0) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        if (rd_any && head_ctrl_g != '0) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    out_wr_d   = rd_any;
    out_data_d = out_data_q;
    out_ctrl_d = out_ctrl_q;
    if (rd_any) begin
      out_data_d = head_data_g;
      out_ctrl_d = head_ctrl_g;
    end

    ring_d = {reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in};
  end

  // FIFO storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (wr_en[i]) begin
        mem_data_q[i][wr_ptr_q[i]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
        mem_ctrl_q[i][wr_ptr_q[i]] <= in_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_RST;
      out_wr_q     <= 1'b0;
      out_data_q   <= '0;
      out_ctrl_q   <= '0;
      ring_q       <= '0;
      for (int i = 0; i < NUM_QUEUES; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      out_wr_q     <= out_wr_d;
      out_data_q   <= out_data_d;
      out_ctrl_q   <= out_ctrl_d;
      ring_q       <= ring_d;
      for (int i = 0; i < NUM_QUEUES; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  assign in_rdy   = ~nearly_full;
  assign out_wr   = out_wr_q;
  assign out_data = out_data_q;
  assign out_ctrl = out_ctrl_q;
  assign {reg_req_out, reg_ack_out, reg_rd_wr_L_out,
          reg_addr_out, reg_data_out, reg_src_out} = ring_q;

endmodule

// File: tb/tb_rr_input_arbiter.sv
// Scoreboard bench for rr_input_arbiter: per-input expected word queues plus a
// packet-level round-robin model predicting grant order.
module tb_rr_input_arbiter;
  localparam int DW = 64, CW = 8, NQ = 4, SW = 2, AW = 23, RDW = 32;

  typedef logic [DW+CW-1:0] word_t;  // {ctrl, data}
  typedef struct {int src; int sop; int eop; int len; int gaps;} pkt_t;

  logic clk = 1'b0;
  logic rst;
  logic [NQ*DW-1:0] in_data = '0;
  logic [NQ*CW-1:0] in_ctrl = '0;
  logic [NQ-1:0]    in_wr = '0;
  logic [NQ-1:0]    in_rdy;
  logic [DW-1:0]    out_data;
  logic [CW-1:0]    out_ctrl;
  logic             out_wr;
  logic             out_rdy;
  logic             reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [AW-1:0]    reg_addr_in;
  logic [RDW-1:0]   reg_data_in;
  logic [SW-1:0]    reg_src_in;
  logic             reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [AW-1:0]    reg_addr_out;
  logic [RDW-1:0]   reg_data_out;
  logic [SW-1:0]    reg_src_out;

  rr_input_arbiter dut (
    .clk(clk), .reset(rst),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out)
  );

  always #5 clk = ~clk;

  word_t   drv_q [NQ][$];
  word_t   exp_q [NQ][$];
  word_t   pkt_buf[$];
  int      order_q[$];
  pkt_t    log_q[$];
  int      total = 0, bad = 0, cyc = 0, seq = 0, words_out = 0;
  int      model_last = NQ-1;
  int      sop_wr_cyc [NQ];
  logic [NQ-1:0] gap_en = '0;
  logic [NQ-1:0] nf_seen = '0;

  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [DW+CW-1:0] act, input logic [DW+CW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Grant order from packet-level pending set, lowest distance after last winner.
  function automatic int rr_model(input logic [NQ-1:0] pend);
    for (int k = 1; k <= NQ; k++) begin
      int c;
      c = (model_last + k) % NQ;
      if (pend[c]) begin
        model_last = c;
        return c;
      end
    end
    return -1;
  endfunction

  // data = {src[3:0], seq[11:0], idx[7:0], random[39:0]}
  task automatic make_pkt(input int src, input int len, input logic [7:0] ectl);
    pkt_buf.delete();
    seq++;
    for (int k = 0; k < len; k++) begin
      logic [7:0] c;
      c = (k == 0) ? 8'hFF : (k == len-1) ? ectl : 8'h00;
      pkt_buf.push_back({c, 4'(src), 12'(seq), 8'(k), 40'({$urandom, $urandom})});
    end
  endtask

  task automatic send(input int src, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      drv_q[src].push_back(pkt_buf[k]);
      exp_q[src].push_back(pkt_buf[k]);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic bit busy();
    for (int i = 0; i < NQ; i++)
      if (drv_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      step(1);
      n++;
    end
    chk(name, {71'd0, busy()}, 72'd0);
  endtask

  task automatic clear_tb();
    for (int i = 0; i < NQ; i++) begin
      drv_q[i].delete();
      exp_q[i].delete();
    end
    order_q.delete();
    model_last = NQ-1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_tb();
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  // Driver: one word per input per cycle while the FIFO reports ready.
  always @(negedge clk) begin
    word_t w;
    for (int i = 0; i < NQ; i++) begin
      in_wr[i] = 1'b0;
      if (!rst && drv_q[i].size() > 0 && in_rdy[i] &&
          !(gap_en[i] && $urandom_range(0, 3) == 0)) begin
        w = drv_q[i].pop_front();
        in_data[i*DW +: DW] = w[DW-1:0];
        in_ctrl[i*CW +: CW] = w[DW+CW-1:DW];
        if (w[47:40] == 8'd0) sop_wr_cyc[i] = cyc;
        in_wr[i] = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard for every output word.
  logic in_pkt = 1'b0;
  logic pay_seen = 1'b0;
  int   cur_src, cur_sop, cur_len, cur_gaps;
  always @(negedge clk) begin
    int s;
    for (int i = 0; i < NQ; i++) if (!in_rdy[i]) nf_seen[i] = 1'b1;
    if (rst) begin
      in_pkt = 1'b0;
    end else if (out_wr) begin
      s = int'(out_data[63:60]);
      words_out++;
      if (!in_pkt) begin
        in_pkt = 1'b1; pay_seen = 1'b0;
        cur_src = s; cur_sop = cyc; cur_len = 0; cur_gaps = 0;
        if (order_q.size() > 0) chk("rr_order", 72'(s), 72'(order_q.pop_front()));
      end else begin
        chk("no_interleave", 72'(s), 72'(cur_src));
      end
      cur_len++;
      if (s >= NQ || exp_q[s].size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_word: actual=%0h required=none", {out_ctrl, out_data});
      end else begin
        chk("word", {out_ctrl, out_data}, exp_q[s].pop_front());
      end
      if (out_ctrl == '0) pay_seen = 1'b1;
      else if (pay_seen) begin
        in_pkt = 1'b0;
        log_q.push_back('{src: cur_src, sop: cur_sop, eop: cyc, len: cur_len, gaps: cur_gaps});
      end
    end else if (in_pkt) begin
      cur_gaps++;
    end
  end

  initial begin
    int n0, lat, n;
    int cnt [NQ];
    logic [NQ-1:0] pend;
    word_t hold_q[$];

    rst = 1'b1; out_rdy = 1'b1;
    reg_req_in = 0; reg_ack_in = 0; reg_rd_wr_L_in = 0;
    reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
    step(3);
    chk("rst_out_wr", 72'(out_wr), 72'd0);
    chk("rst_out_data", 72'(out_data), 72'd0);
    chk("rst_out_ctrl", 72'(out_ctrl), 72'd0);
    chk("rst_in_rdy", 72'(in_rdy), 72'hF);
    chk("rst_ring", 72'({reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out,
                         reg_data_out, reg_src_out}), 72'd0);
    rst = 1'b0;
    step(1);

    // single packet on input 2
    make_pkt(2, 5, 8'h0F);
    order_q.push_back(rr_model(4'b0100));
    send(2, 0, 4);
    wait_drain("t1_drain", 50);
    step(2);
    chk("t1_len", 72'(log_q[log_q.size()-1].len), 72'd5);
    chk("t1_gaps", 72'(log_q[log_q.size()-1].gaps), 72'd0);
    lat = log_q[log_q.size()-1].sop - (sop_wr_cyc[2] + 1);
    chk("t1_latency_2to3", 72'(lat >= 2 && lat <= 3), 72'd1);

    // two 4-word packets per input, released together
    do_reset();
    n0 = log_q.size();
    for (int s = 0; s < NQ; s++) begin
      cnt[s] = 2;
      for (int p = 0; p < 2; p++) begin
        make_pkt(s, 4, 8'hFF);
        send(s, 0, 3);
      end
    end
    for (int p = 0; p < 2*NQ; p++) begin
      for (int s = 0; s < NQ; s++) pend[s] = (cnt[s] > 0);
      n = rr_model(pend);
      order_q.push_back(n);
      cnt[n]--;
    end
    wait_drain("t2_drain", 200);
    step(3);
    chk("t2_npkts", 72'(log_q.size() - n0), 72'd8);
    for (int k = 1; k < 8 && n0 + k < log_q.size(); k++) begin
      chk("t2_idle_gap", 72'(log_q[n0+k].sop - log_q[n0+k-1].eop), 72'd2);
      chk("t2_no_gaps", 72'(log_q[n0+k].gaps), 72'd0);
    end

    // in1 stalls mid-payload while in3 waits
    make_pkt(1, 6, 8'h3F);
    send(1, 0, 2);
    hold_q.delete();
    for (int k = 3; k < 6; k++) hold_q.push_back(pkt_buf[k]);
    make_pkt(3, 4, 8'h01);
    send(3, 0, 3);
    order_q.push_back(rr_model(4'b1010));
    order_q.push_back(rr_model(4'b1000));
    n = 0;
    while (exp_q[1].size() != 0 && n < 40) begin step(1); n++; end
    chk("t3_first_part", 72'(exp_q[1].size()), 72'd0);
    for (int k = 0; k < 6; k++) begin
      step(1);
      chk("t3_stall_quiet", 72'(out_wr), 72'd0);
    end
    chk("t3_in3_held", 72'(exp_q[3].size()), 72'd4);
    foreach (hold_q[k]) begin
      drv_q[1].push_back(hold_q[k]);
      exp_q[1].push_back(hold_q[k]);
    end
    wait_drain("t3_drain", 100);
    step(2);
    chk("t3_in1_stalled", 72'(log_q[log_q.size()-2].gaps >= 6), 72'd1);

    // out_rdy toggling during a 10-word packet
    nf_seen = '0;
    make_pkt(0, 10, 8'hFF);
    order_q.push_back(rr_model(4'b0001));
    send(0, 0, 9);
    n = 0;
    while (busy() && n < 100) begin
      out_rdy = ~out_rdy;
      step(1);
      n++;
    end
    out_rdy = 1'b1;
    wait_drain("t4_drain", 20);
    step(2);
    chk("t4_len", 72'(log_q[log_q.size()-1].len), 72'd10);
    chk("t4_nf_seen", 72'(nf_seen[0]), 72'd1);

    // out_rdy held low: writer stops at nearly_full
    out_rdy = 1'b0;
    make_pkt(2, 6, 8'h07);
    order_q.push_back(rr_model(4'b0100));
    send(2, 0, 5);
    step(8);
    chk("t4b_drv_left", 72'(drv_q[2].size()), 72'd3);
    chk("t4b_in_rdy", 72'(in_rdy), 72'b1011);
    chk("t4b_out_wr", 72'(out_wr), 72'd0);
    out_rdy = 1'b1;
    wait_drain("t4b_drain", 50);

    // reset mid-packet on in0
    make_pkt(0, 8, 8'hFF);
    order_q.push_back(rr_model(4'b0001));
    send(0, 0, 7);
    n0 = words_out; n = 0;
    while (words_out < n0 + 3 && n < 40) begin step(1); n++; end
    chk("t5_reached_word3", 72'(words_out >= n0 + 3), 72'd1);
    rst = 1'b1;
    #1;
    chk("t5_async_out_wr", 72'(out_wr), 72'd0);
    chk("t5_async_out_data", 72'(out_data), 72'd0);
    chk("t5_fifos_flushed", 72'(in_rdy), 72'hF);
    clear_tb();
    step(1);
    rst = 1'b0;
    step(1);
    make_pkt(1, 5, 8'h1F);
    order_q.push_back(rr_model(4'b0010));
    send(1, 0, 4);
    wait_drain("t5_in1_drain", 50);
    do_reset();
    make_pkt(1, 4, 8'hFF); send(1, 0, 3);
    make_pkt(0, 4, 8'hFF); send(0, 0, 3);
    order_q.push_back(rr_model(4'b0011));
    order_q.push_back(rr_model(4'b0010));
    wait_drain("t5_first_grant_drain", 50);

    // register ring pass-through
    reg_req_in = 1; reg_ack_in = 0; reg_rd_wr_L_in = 1;
    reg_addr_in = 23'h123; reg_data_in = 32'hDEADBEEF; reg_src_in = 2'd1;
    #1;
    chk("t6_not_early", 72'(reg_addr_out), 72'd0);
    step(1);
    chk("t6_ring_a", 72'({reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out,
                          reg_data_out, reg_src_out}),
        72'({1'b1, 1'b0, 1'b1, 23'h123, 32'hDEADBEEF, 2'd1}));
    reg_req_in = 0; reg_ack_in = 1; reg_rd_wr_L_in = 0;
    reg_addr_in = 23'h5A5A5; reg_data_in = 32'h12345678; reg_src_in = 2'd2;
    step(1);
    chk("t6_ring_b", 72'({reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out,
                          reg_data_out, reg_src_out}),
        72'({1'b0, 1'b1, 1'b0, 23'h5A5A5, 32'h12345678, 2'd2}));

    // randomized traffic with input gaps and downstream backpressure
    do_reset();
    gap_en = '1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        n = $urandom_range(0, NQ-1);
        make_pkt(n, $urandom_range(3, 9), 8'hFF >> $urandom_range(0, 7));
        send(n, 0, pkt_buf.size()-1);
      end
      out_rdy = ($urandom_range(0, 3) != 0);
      step(1);
    end
    out_rdy = 1'b1;
    wait_drain("rand_drain", 3000);
    gap_en = '0;
    step(4);
    chk("final_idle", 72'(out_wr), 72'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
